lp805x_ntcin: RTL

Input conditioner for the new timer's external count pin. It sits directly upstream of the timer's pin_cnt input, on the timer's internal clock domain.
- Synchronises the asynchronous port pin.
- Filters glitches with a programmable sample rate and stability length.
- Selects the counting edge.
- Emits one single-cycle high pulse on pin_cnt per qualified edge. The timer counts one event on the pulse's falling edge.
- Keeps pulses spaced at least one low cycle apart, with overrun reporting.

---
 rtl/lp805x_ntcin_pkg.sv | 28 ++
 rtl/lp805x_ntcin_sync.sv | 22 ++
 rtl/lp805x_ntcin.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/lp805x_ntcin_pkg.sv
// Shared encodings for the new-timer count-pin conditioner: edge-select codes,
// filter FSM states and the edge qualification helper.
package lp805x_ntcin_pkg;

  localparam logic [1:0] LP805X_NTCIN_EDGE_FALL = 2'b00;
  localparam logic [1:0] LP805X_NTCIN_EDGE_RISE = 2'b01;
  localparam logic [1:0] LP805X_NTCIN_EDGE_BOTH = 2'b10;
  localparam logic [1:0] LP805X_NTCIN_EDGE_NONE = 2'b11;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CAND   = 1'b1
  } flt_state_t;

  // rising = new filtered level is 1 (a 0->1 commit)
  function automatic logic edge_qualifies(input logic [1:0] sel, input logic rising);
    logic q;
    q = 1'b0;
    case (sel)
      LP805X_NTCIN_EDGE_FALL: q = ~rising;
      LP805X_NTCIN_EDGE_RISE: q = rising;
      LP805X_NTCIN_EDGE_BOTH: q = 1'b1;
      default:                q = 1'b0;
    endcase
    return q;
  endfunction

endpackage

// File: rtl/lp805x_ntcin_sync.sv
// Reset-valued flop-chain synchroniser for asynchronous port pins.
// SYNC_STAGES must be at least 2.
module lp805x_ntcin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_LVL     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge clk) begin
    if (!rst) r_chain <= {SYNC_STAGES{RST_LVL}};
    else      r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/lp805x_ntcin.sv
// Count-pin conditioner for the new timer: sync, sampled glitch filter, edge
// select and spaced single-cycle pulses. Glitch counter built only when
// LP805X_NTCIN_GLITCHCNT_EN is defined.
module lp805x_ntcin
  import lp805x_ntcin_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   SDIV_W      = 8,
  parameter int   FLEN_W      = 4,
  parameter logic RST_LVL     = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pin_raw,
  input  logic              en,
  input  logic [1:0]        edge_sel,
  input  logic [SDIV_W-1:0] smp_div,
  input  logic [FLEN_W-1:0] flt_len,
  input  logic              ovr_clr,
  output logic              pin_cnt,
  output logic              flt_lvl,
  output logic              ovr,
  output logic [7:0]        glitch_cnt
);

  logic              w_s;
  logic              w_tick;
  logic              w_diff;
  logic [SDIV_W-1:0] r_pcnt;

  flt_state_t        r_state, w_state_nxt;
  logic [FLEN_W-1:0] r_scnt, w_scnt_nxt, w_scnt_inc;
  logic              r_flt_lvl;
  logic              w_commit;
  logic              r_qual;

  logic              r_pin_cnt, w_pin_nxt;
  logic              r_pend, w_pend_nxt;
  logic              w_ovr_set;
  logic              r_ovr;

  lp805x_ntcin_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_LVL    (RST_LVL)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .i_d(pin_raw),
    .o_q(w_s)
  );

  // >= lets a smaller smp_div take effect on the very next cycle
  assign w_tick = en & (r_pcnt >= smp_div);
  assign w_diff = (w_s != r_flt_lvl);

  always_ff @(posedge clk) begin
    if (!rst || !en) r_pcnt <= '0;
    else if (w_tick) r_pcnt <= '0;
    else             r_pcnt <= r_pcnt + 1'b1;
  end

  assign w_scnt_inc = r_scnt + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    w_scnt_nxt  = r_scnt;
    w_commit    = 1'b0;
    if (!en) begin
      w_state_nxt = ST_STABLE;
      w_scnt_nxt  = '0;
    end else if (flt_len == '0) begin
      w_state_nxt = ST_STABLE;
      w_scnt_nxt  = '0;
      w_commit    = w_diff;
    end else begin
      case (r_state)
        ST_STABLE: begin
          if (w_tick && w_diff) begin
            if (flt_len <= FLEN_W'(1)) begin
              w_commit = 1'b1;
            end else begin
              w_state_nxt = ST_CAND;
              w_scnt_nxt  = FLEN_W'(1);
            end
          end
        end
        ST_CAND: begin
          if (w_tick) begin
            if (!w_diff) begin
              w_state_nxt = ST_STABLE;
              w_scnt_nxt  = '0;
            end else if (w_scnt_inc >= flt_len) begin
              w_commit    = 1'b1;
              w_state_nxt = ST_STABLE;
              w_scnt_nxt  = '0;
            end else begin
              w_scnt_nxt  = w_scnt_inc;
            end
          end
        end
        default: begin
          w_state_nxt = ST_STABLE;
          w_scnt_nxt  = '0;
        end
      endcase
    end
  end

  // While disabled the level tracks the pin so re-enabling creates no edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_STABLE;
      r_scnt    <= '0;
      r_flt_lvl <= RST_LVL;
      r_qual    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_scnt  <= w_scnt_nxt;
      if (!en || w_commit) r_flt_lvl <= w_s;
      r_qual  <= en & w_commit & edge_qualifies(edge_sel, w_s);
    end
  end

  // Handshake-free pulse spacing: one pending slot absorbs an edge that lands
  // while pin_cnt is high; a further edge before it drains is an overrun.
  always_comb begin
    w_pin_nxt  = 1'b0;
    w_pend_nxt = r_pend;
    w_ovr_set  = 1'b0;
    if (!en) begin
      w_pend_nxt = 1'b0;
    end else if (r_pin_cnt) begin
      if (r_qual) begin
        if (r_pend) w_ovr_set  = 1'b1;
        else        w_pend_nxt = 1'b1;
      end
    end else if (r_pend) begin
      w_pin_nxt  = 1'b1;
      w_pend_nxt = 1'b0;
      w_ovr_set  = r_qual;
    end else begin
      w_pin_nxt  = r_qual;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pin_cnt <= 1'b0;
      r_pend    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_pin_cnt <= w_pin_nxt;
      r_pend    <= w_pend_nxt;
      if (w_ovr_set)    r_ovr <= 1'b1;
      else if (ovr_clr) r_ovr <= 1'b0;
    end
  end

`ifdef LP805X_NTCIN_GLITCHCNT_EN
  logic       w_glitch;
  logic [7:0] r_glitch_cnt;

  assign w_glitch = en & (flt_len != '0) & (r_state == ST_CAND) & w_tick & ~w_diff;

  always_ff @(posedge clk) begin
    if (!rst)                             r_glitch_cnt <= 8'h00;
    else if (ovr_clr)                     r_glitch_cnt <= {7'h00, w_glitch};
    else if (w_glitch && r_glitch_cnt != 8'hFF) r_glitch_cnt <= r_glitch_cnt + 8'h01;
  end

  assign glitch_cnt = r_glitch_cnt;
`else
  assign glitch_cnt = 8'h00;
`endif

  assign pin_cnt = r_pin_cnt;
  assign flt_lvl = r_flt_lvl;
  assign ovr     = r_ovr;

endmodule
